vga_fetch: RTL and testbench

//  Downstream consumer of the data memory's second (read-only) port: scans a cell-colour framebuffer out to a 640x480@60 VGA DAC.
//  Per cell row, an FSM burst-reads GRID_W words via addr2/dataOut2 into a line buffer during horizontal blanking.
//  It then replays the buffer as pixels. Port 1 stays owned by the CPU; this block never writes memory.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing.sv | 98 +++++++++
 rtl/vga_fetch.sv | 173 +++++++++++++++++
 tb/tb_vga_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, fetch FSM state encoding and RGB332 colour expansion.
package vga_pkg;

   localparam logic [9:0] H_VIS    = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_TOT    = 10'd800;
   localparam logic [9:0] V_VIS    = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_TOT    = 10'd525;

   localparam logic [9:0] HS_START = H_VIS + H_FP;
   localparam logic [9:0] HS_END   = H_VIS + H_FP + H_SYNC;
   localparam logic [9:0] VS_START = V_VIS + V_FP;
   localparam logic [9:0] VS_END   = V_VIS + V_FP + V_SYNC;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_e;

   // Bit replication spreads each 3/3/2-bit field across the full 8-bit DAC range.
   function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] w);
      return {w[7:5], w[7:5], w[7:6],
              w[4:2], w[4:2], w[4:3],
              {4{w[1:0]}}};
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel tick, h/v raster counters with cell column/row sub-counters, raw sync/visible flags.
module vga_timing import vga_pkg::*; #(
   parameter int CELL_PX = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   output logic       pix_tick_o,
   output logic [9:0] h_o,
   output logic [9:0] v_o,
   output logic [6:0] col_o,
   output logic [3:0] cx_o,
   output logic [6:0] vrow_o,
   output logic [3:0] vy_o,
   output logic       hs_o,
   output logic       vs_o,
   output logic       visible_o,
   output logic       frame_first_o
);

   localparam logic [3:0] CELL_LAST = 4'(CELL_PX - 1);

   logic       tog_q, tog_d;
   logic [9:0] h_q, h_d, v_q, v_d;
   logic [6:0] col_q, col_d, vrow_q, vrow_d;
   logic [3:0] cx_q, cx_d, vy_q, vy_d;

   always_comb begin
      tog_d  = ~tog_q;
      h_d    = h_q;
      v_d    = v_q;
      col_d  = col_q;
      cx_d   = cx_q;
      vrow_d = vrow_q;
      vy_d   = vy_q;
      if (tog_q) begin
         if (h_q == H_TOT - 10'd1) begin
            h_d   = '0;
            col_d = '0;
            cx_d  = '0;
            if (v_q == V_TOT - 10'd1) begin
               v_d    = '0;
               vrow_d = '0;
               vy_d   = '0;
            end else begin
               v_d = v_q + 10'd1;
               if (vy_q == CELL_LAST) begin
                  vy_d   = '0;
                  vrow_d = vrow_q + 7'd1;
               end else begin
                  vy_d = vy_q + 4'd1;
               end
            end
         end else begin
            h_d = h_q + 10'd1;
            if (cx_q == CELL_LAST) begin
               cx_d  = '0;
               col_d = col_q + 7'd1;
            end else begin
               cx_d = cx_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tog_q  <= 1'b0;
         h_q    <= '0;
         v_q    <= '0;
         col_q  <= '0;
         cx_q   <= '0;
         vrow_q <= '0;
         vy_q   <= '0;
      end else begin
         tog_q  <= tog_d;
         h_q    <= h_d;
         v_q    <= v_d;
         col_q  <= col_d;
         cx_q   <= cx_d;
         vrow_q <= vrow_d;
         vy_q   <= vy_d;
      end
   end

   assign pix_tick_o    = tog_q;
   assign h_o           = h_q;
   assign v_o           = v_q;
   assign col_o         = col_q;
   assign cx_o          = cx_q;
   assign vrow_o        = vrow_q;
   assign vy_o          = vy_q;
   assign hs_o          = !((h_q >= HS_START) && (h_q < HS_END));
   assign vs_o          = !((v_q >= VS_START) && (v_q < VS_END));
   assign visible_o     = (h_q < H_VIS) && (v_q < V_VIS);
   // First clk of pixel (0,0) only, so the pulse is one system clock wide.
   assign frame_first_o = (h_q == '0) && (v_q == '0) && !tog_q;

endmodule

// File: rtl/vga_fetch.sv
// Framebuffer scan-out: burst-reads one cell row into a line buffer during hblank, replays it as
// RGB332-expanded pixels. Define VGA_GRIDLINE_EN to overlay a dim grid on cell edges.
module vga_fetch import vga_pkg::*; #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] FB_BASE    = ADDR_WIDTH'('h8000),
   parameter int                    GRID_W     = 64,
   parameter int                    GRID_H     = 48,
   parameter int                    CELL_PX    = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  vga_clk,
   output logic                  vga_hs,
   output logic                  vga_vs,
   output logic                  vga_blank_n,
   output logic [7:0]            vga_r,
   output logic [7:0]            vga_g,
   output logic [7:0]            vga_b,
   output logic                  frame_start,
   output logic                  fetch_busy
);

   localparam int               IDX_W       = $clog2(GRID_W);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(GRID_W - 1);
   localparam logic [3:0]       CELL_LAST   = 4'(CELL_PX - 1);
   localparam logic [9:0]       FETCH_V_MAX = 10'(GRID_H * CELL_PX - 1);

   logic       pix_tick, hs, vs, visible, frame_first;
   logic [9:0] h, v;
   logic [6:0] col, vrow;
   logic [3:0] cx, vy;

   vga_timing #(.CELL_PX(CELL_PX)) u_timing (
      .clk_i         (clk),
      .rst_i         (reset),
      .pix_tick_o    (pix_tick),
      .h_o           (h),
      .v_o           (v),
      .col_o         (col),
      .cx_o          (cx),
      .vrow_o        (vrow),
      .vy_o          (vy),
      .hs_o          (hs),
      .vs_o          (vs),
      .visible_o     (visible),
      .frame_first_o (frame_first)
   );

   fetch_state_e          state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, wr_idx_q, wr_idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_en_q, wr_en_d, row_valid_q, row_valid_d;
   logic                  trigger;
   logic [6:0]            trig_row;
   logic [7:0]            linebuf_q [GRID_W];
   logic [23:0]           rgb_q, rgb_d;
   logic                  hs_q, vs_q, blank_n_q, frame_q;
   logic                  unused_ok;

   // Fetch the row displayed on line v+1; the last line of the frame prefetches row 0.
   assign trigger  = pix_tick && (h == H_VIS) &&
                     ((v == V_TOT - 10'd1) || ((v < FETCH_V_MAX) && (vy == CELL_LAST)));
   assign trig_row = (v == V_TOT - 10'd1) ? 7'd0 : vrow + 7'd1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      row_valid_d = row_valid_q;
      wr_en_d     = 1'b0;
      wr_idx_d    = idx_q;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = FETCH;
               idx_d   = '0;
               addr_d  = FB_BASE + ADDR_WIDTH'(trig_row) * ADDR_WIDTH'(GRID_W);
            end
         end
         FETCH: begin
            // Memory answers one clk later, so the write trails the issued index by a cycle.
            wr_en_d = 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = DRAIN;
            end else begin
               idx_d  = idx_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            row_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_idx_q    <= '0;
         row_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wr_idx_q    <= wr_idx_d;
         row_valid_q <= row_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_q) begin
         linebuf_q[wr_idx_q] <= mem_data[7:0];
      end
   end

   always_comb begin
      rgb_d = '0;
      if (visible && row_valid_q) begin
         rgb_d = rgb332_to_rgb888(linebuf_q[col[IDX_W-1:0]]);
`ifdef VGA_GRIDLINE_EN
         if ((cx == '0) || (vy == '0)) begin
            rgb_d = {3{8'h20}};
         end
`endif
      end
   end

`ifdef VGA_GRIDLINE_EN
   assign unused_ok = ^{mem_data[DATA_WIDTH-1:8], col[6:IDX_W]};
`else
   assign unused_ok = ^{mem_data[DATA_WIDTH-1:8], col[6:IDX_W], cx};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         frame_q   <= 1'b0;
         rgb_q     <= '0;
      end else begin
         hs_q      <= hs;
         vs_q      <= vs;
         blank_n_q <= visible;
         frame_q   <= frame_first;
         rgb_q     <= rgb_d;
      end
   end

   assign mem_addr    = addr_q;
   assign mem_we      = 1'b0;
   assign vga_clk     = pix_tick;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign frame_start = frame_q;
   assign fetch_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_vga_fetch.sv
// Self-checking bench for vga_fetch: clk counting from reset release, synchronous memory model,
// queued expectations for sync edges, fetch addresses and pixel colours.
module tb_vga_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_data;
   logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        frame_start, fetch_busy;

   logic [15:0] mem [0:65535];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          fall_q[$];
   logic [15:0] addr_q[$];
   logic [23:0] pix_q[$];

   vga_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_data    (mem_data),
      .vga_clk     (vga_clk),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start),
      .fetch_busy  (fetch_busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) mem_data <= mem[mem_addr];

   // cyc == n while sampling just after the n-th rising edge since reset release.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at clk %0d", cyc);
      $fatal(1);
   end

   task automatic step_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Row 1 holds 0x1C (pure green) except cell 5, which is 0xE3 (magenta).
   function automatic logic [23:0] exp_row1(input int x, input int v);
`ifdef VGA_GRIDLINE_EN
      if ((x % 10) == 0 || (v % 10) == 0) return 24'h202020;
`endif
      if (x >= 50 && x <= 59) return 24'hFF00FF;
      return 24'h00FF00;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({vga_hs, vga_vs, vga_blank_n, frame_start, fetch_busy, mem_we, vga_clk} !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 1100000", {vga_hs, vga_vs, vga_blank_n, frame_start, fetch_busy, mem_we, vga_clk});
      end
      checks++;
      if ({vga_r, vga_g, vga_b} !== 24'h0) begin
         errors++;
         $display("FAIL reset_rgb: got %h want 000000", {vga_r, vga_g, vga_b});
      end
      checks++;
      if (mem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h want 0000", mem_addr);
      end
      @(negedge clk);
      reset = 1'b0;
      step_to(1);
      checks++;
      if ({frame_start, vga_clk} !== 2'b11) begin
         errors++;
         $display("FAIL first_frame_start: got fs,vga_clk=%b want 11", {frame_start, vga_clk});
      end
      step_to(2);
      checks++;
      if ({frame_start, vga_clk} !== 2'b00) begin
         errors++;
         $display("FAIL frame_start_width: got fs,vga_clk=%b want 00", {frame_start, vga_clk});
      end
   endtask

   task automatic test_hsync();
      logic prev;
      int   e;
      fall_q.push_back(1313);
      fall_q.push_back(1313 + 1600);
      prev = vga_hs;
      for (int n = cyc + 1; n <= 3300; n++) begin
         step_to(n);
         if (prev && !vga_hs) begin
            checks++;
            if (fall_q.size() == 0) begin
               errors++;
               $display("FAIL hs_fall_extra: fall at clk %0d, none expected", cyc);
            end else begin
               e = fall_q.pop_front();
               if (cyc !== e) begin
                  errors++;
                  $display("FAIL hs_fall: got clk %0d want clk %0d", cyc, e);
               end
            end
         end
         prev = vga_hs;
         if (n == 101) begin
            checks++;
            if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, 24'h0}) begin
               errors++;
               $display("FAIL line0_black: got blank_n=%b rgb=%h want 1 000000", vga_blank_n, {vga_r, vga_g, vga_b});
            end
         end
         if (n == 1400) begin
            checks++;
            if ({vga_blank_n, vga_r, vga_g, vga_b} !== 25'h0) begin
               errors++;
               $display("FAIL hblank: got blank_n=%b rgb=%h want 0 000000", vga_blank_n, {vga_r, vga_g, vga_b});
            end
         end
      end
      checks++;
      if (fall_q.size() != 0) begin
         errors++;
         $display("FAIL hs_fall_missing: got %0d unseen falls want 0", fall_q.size());
         fall_q.delete();
      end
   endtask

   task automatic test_row_fetch();
      int          s;
      int          bc;
      logic [15:0] ea;
      s = 9 * 1600 + 1281;
      step_to(s);
      checks++;
      if (fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_before_trigger: got %b want 0", fetch_busy);
      end
      for (int i = 0; i < 64; i++) addr_q.push_back(16'h8040 + 16'(i));
      bc = 0;
      for (int k = 1; k <= 80; k++) begin
         step_to(s + k);
         if (fetch_busy === 1'b1) bc++;
         if (addr_q.size() > 0) begin
            ea = addr_q.pop_front();
            checks++;
            if (mem_addr !== ea) begin
               errors++;
               $display("FAIL fetch_addr: clk %0d got %h want %h", cyc, mem_addr, ea);
            end
         end
         checks++;
         if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mem_we: clk %0d got %b want 0", cyc, mem_we);
         end
      end
      checks++;
      if (bc !== 66) begin
         errors++;
         $display("FAIL busy_len: got %0d clks want 66", bc);
      end
      checks++;
      if (mem_addr !== 16'h807F) begin
         errors++;
         $display("FAIL addr_hold: got %h want 807f", mem_addr);
      end
   endtask

   task automatic test_row_advance();
      int          base;
      logic [23:0] ep;
      for (int v = 10; v <= 11; v++) begin
         base = v * 1600;
         for (int x = 0; x < 640; x++) begin
            pix_q.push_back(exp_row1(x, v));
            pix_q.push_back(exp_row1(x, v));
         end
         for (int n = base + 1; n <= base + 1280; n++) begin
            step_to(n);
            ep = pix_q.pop_front();
            checks++;
            if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, ep}) begin
               errors++;
               $display("FAIL pixel: line %0d x %0d got blank_n=%b rgb=%h want 1 %h",
                        v, (n - base - 1) / 2, vga_blank_n, {vga_r, vga_g, vga_b}, ep);
            end
         end
         step_to(base + 1282);
         checks++;
         if ({vga_blank_n, vga_r, vga_g, vga_b} !== 25'h0) begin
            errors++;
            $display("FAIL line_end_blank: line %0d got blank_n=%b rgb=%h want 0 000000",
                     v, vga_blank_n, {vga_r, vga_g, vga_b});
         end
      end
   endtask

   task automatic test_mid_burst_reset();
      int s;
      s = 19 * 1600 + 1281;
      step_to(s + 21);
      checks++;
      if ({fetch_busy, mem_addr} !== {1'b1, 16'h8094}) begin
         errors++;
         $display("FAIL burst_idx20: got busy=%b addr=%h want 1 8094", fetch_busy, mem_addr);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({vga_hs, vga_vs, vga_blank_n, frame_start, fetch_busy, mem_we, vga_clk, mem_addr, vga_r, vga_g, vga_b}
          !== {7'b1100000, 16'h0, 24'h0}) begin
         errors++;
         $display("FAIL async_reset: got ctrl=%b addr=%h rgb=%h want 1100000 0000 000000",
                  {vga_hs, vga_vs, vga_blank_n, frame_start, fetch_busy, mem_we, vga_clk}, mem_addr, {vga_r, vga_g, vga_b});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 3200; n++) begin
         step_to(n);
         checks++;
         if ({fetch_busy, vga_r, vga_g, vga_b} !== 25'h0) begin
            errors++;
            $display("FAIL post_reset_black: clk %0d got busy=%b rgb=%h want 0 000000",
                     cyc, fetch_busy, {vga_r, vga_g, vga_b});
         end
         if (n == 1) begin
            checks++;
            if (frame_start !== 1'b1) begin
               errors++;
               $display("FAIL post_reset_frame_start: got %b want 1", frame_start);
            end
         end
      end
      step_to(16000 + 2 * 51 + 1);
      checks++;
      if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, exp_row1(51, 10)}) begin
         errors++;
         $display("FAIL refetch_pixel: got blank_n=%b rgb=%h want 1 %h",
                  vga_blank_n, {vga_r, vga_g, vga_b}, exp_row1(51, 10));
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
      for (int i = 0; i < 64; i++) begin
         mem[16'h8000 + i] = 16'(i);
         mem[16'h8040 + i] = 16'h5A1C;
         mem[16'h8080 + i] = 16'h00AA;
      end
      mem[16'h8045] = 16'hFFE3;

      test_reset();
      test_hsync();
      test_row_fetch();
      test_row_advance();
      test_mid_burst_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
